// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU control codes, select encodings and register-file sizing
// for the operand stage and anything that drives or checks it.
package alu_operand_stage_pkg;

   localparam int unsigned NREG_DEFAULT = 32;
   localparam int unsigned XLEN         = 32;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0110,
      OP_SLT = 4'b0111,
      OP_NOR = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      SEL_AND  = 2'b00,
      SEL_OR   = 2'b01,
      SEL_SUM  = 2'b10,
      SEL_LESS = 2'b11
   } alu_sel_e;

   typedef struct packed {
      logic     ainvert;
      logic     binvert;
      logic     cin;
      alu_sel_e s;
      logic     err;
   } alu_ctrl_t;

   // Unknown codes fall back to AND and raise err.
   function automatic alu_ctrl_t decode_op(input logic [3:0] op);
      alu_ctrl_t c;
      c = '{ainvert: 1'b0, binvert: 1'b0, cin: 1'b0, s: SEL_AND, err: 1'b0};
      case (op)
         OP_AND:  c.s = SEL_AND;
         OP_OR:   c.s = SEL_OR;
         OP_ADD:  c.s = SEL_SUM;
         OP_SUB:  begin c.binvert = 1'b1; c.cin = 1'b1; c.s = SEL_SUM;  end
         OP_SLT:  begin c.binvert = 1'b1; c.cin = 1'b1; c.s = SEL_LESS; end
         OP_NOR:  begin c.ainvert = 1'b1; c.binvert = 1'b1; c.s = SEL_AND; end
         default: c.err = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports with same-cycle write
// forwarding, one synchronous write port. Register 0 is hardwired to zero.
module regfile_2r1w
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEFAULT,
   parameter int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [AW-1:0]   ra_addr,
   output logic [XLEN-1:0] ra_data,
   input  logic [AW-1:0]   rb_addr,
   output logic [XLEN-1:0] rb_data
);

   logic [XLEN-1:0] mem [NREG];

   // Clear everything on reset; otherwise commit writes to nonzero registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (wr_en && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Port A read: zero for r0, forward a same-cycle write, else storage.
   always_comb begin
      ra_data = '0;
      if (ra_addr != '0) begin
         if (wr_en && (wr_addr == ra_addr)) ra_data = wr_data;
         else                               ra_data = mem[ra_addr];
      end
   end

   // Port B read: same rules as port A.
   always_comb begin
      rb_data = '0;
      if (rb_addr != '0) begin
         if (wr_en && (wr_addr == rb_addr)) rb_data = wr_data;
         else                               rb_data = mem[rb_addr];
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: reads sources from the register file, selects the
// immediate, decodes the ALU control code and holds the result in a
// one-deep valid/ready output register.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic        in_use_imm,
   input  logic [15:0] in_imm,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic        cin,
   output logic        Ainvert,
   output logic        Binvert,
   output logic [1:0]  s,
   output logic        err
);

   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [XLEN-1:0] rs_data;
   logic [XLEN-1:0] rt_data;
   logic [XLEN-1:0] b_next;
   alu_ctrl_t       ctrl_next;
   alu_ctrl_t       ctrl_q;
   logic            accept;

   regfile_2r1w #(
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr[AW-1:0]),
      .wr_data (wr_data),
      .ra_addr (in_rs[AW-1:0]),
      .ra_data (rs_data),
      .rb_addr (in_rt[AW-1:0]),
      .rb_data (rt_data)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Operand B selection and control decode for the incoming request.
   always_comb begin
      b_next    = in_use_imm ? {{16{in_imm[15]}}, in_imm} : rt_data;
      ctrl_next = decode_op(in_op);
   end

   // One-deep output register: load on accept, drain on consume, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         a         <= '0;
         b         <= '0;
         ctrl_q    <= '{ainvert: 1'b0, binvert: 1'b0, cin: 1'b0, s: SEL_AND, err: 1'b0};
      end else if (accept) begin
         out_valid <= 1'b1;
         a         <= rs_data;
         b         <= b_next;
         ctrl_q    <= ctrl_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign Ainvert = ctrl_q.ainvert;
   assign Binvert = ctrl_q.binvert;
   assign cin     = ctrl_q.cin;
   assign s       = ctrl_q.s;
   assign err     = ctrl_q.err;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic        in_use_imm;
   logic [15:0] in_imm;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        Ainvert;
   logic        Binvert;
   logic [1:0]  s;
   logic        err;

   logic [5:0]  ctrl_obs;
   int          checks;
   int          errors;

   assign ctrl_obs = {Ainvert, Binvert, cin, s, err};

   alu_operand_stage #(.NREG(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_use_imm (in_use_imm),
      .in_imm     (in_imm),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .Ainvert    (Ainvert),
      .Binvert    (Binvert),
      .s          (s),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_imm, input logic [15:0] imm);
      in_valid   = 1'b1;
      in_op      = op;
      in_rs      = rs;
      in_rt      = rt;
      in_use_imm = use_imm;
      in_imm     = imm;
   endtask

   task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b0, 32'h0, 32'h0, 6'b000000}) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b a=%h b=%h ctrl=%b, want 0/0/0/000000",
                  out_valid, a, b, ctrl_obs);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_sub();
      out_ready = 1'b1;
      write_reg(5'd5, 32'h0000_0007);
      tick();
      write_reg(5'd6, 32'h0000_0003);
      tick();
      wr_en = 1'b0;
      issue(OP_SUB, 5'd5, 5'd6, 1'b0, 16'h0);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'd7, 32'd3, 6'b011_10_0}) begin
         errors++;
         $display("FAIL sub_bundle: got valid=%b a=%h b=%h ctrl=%b, want 1/7/3/011100",
                  out_valid, a, b, ctrl_obs);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL sub_drain: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_imm();
      issue(OP_ADD, 5'd5, 5'd6, 1'b1, 16'hFFFE);
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'd7, 32'hFFFF_FFFE, 6'b000_10_0}) begin
         errors++;
         $display("FAIL imm_negative: got valid=%b a=%h b=%h ctrl=%b, want 1/7/fffffffe/000100",
                  out_valid, a, b, ctrl_obs);
      end
      issue(OP_ADD, 5'd5, 5'd6, 1'b1, 16'h7FFF);
      tick();
      checks++;
      if (b !== 32'h0000_7FFF) begin
         errors++;
         $display("FAIL imm_positive: got b=%h want 00007fff", b);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_forward();
      write_reg(5'd9, 32'h0000_1234);
      issue(OP_OR, 5'd9, 5'd0, 1'b0, 16'h0);
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'h1234, 32'h0, 6'b000_01_0}) begin
         errors++;
         $display("FAIL forward_rs: got valid=%b a=%h b=%h ctrl=%b, want 1/1234/0/000010",
                  out_valid, a, b, ctrl_obs);
      end
      write_reg(5'd0, 32'hFFFF_FFFF);
      issue(OP_AND, 5'd0, 5'd0, 1'b0, 16'h0);
      tick();
      checks++;
      if ({a, b} !== {32'h0, 32'h0}) begin
         errors++;
         $display("FAIL r0_no_forward: got a=%h b=%h want 0/0", a, b);
      end
      wr_en = 1'b0;
      issue(OP_AND, 5'd0, 5'd9, 1'b0, 16'h0);
      tick();
      checks++;
      if ({a, b} !== {32'h0, 32'h1234}) begin
         errors++;
         $display("FAIL r0_stored: got a=%h b=%h want 0/1234", a, b);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_decode();
      logic [3:0] ops [8];
      logic [5:0] exp [8];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101, 4'b1111};
      exp = '{6'b000_00_0, 6'b000_01_0, 6'b000_10_0, 6'b011_10_0,
              6'b011_11_0, 6'b110_00_0, 6'b000_00_1, 6'b000_00_1};
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], 5'd5, 5'd6, 1'b0, 16'h0);
         tick();
         checks++;
         if ({out_valid, ctrl_obs} !== {1'b1, exp[i]}) begin
            errors++;
            $display("FAIL decode_op_%b: got valid=%b ctrl=%b, want 1/%b",
                     ops[i], out_valid, ctrl_obs, exp[i]);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      issue(OP_ADD, 5'd5, 5'd6, 1'b0, 16'h0);
      tick();
      checks++;
      if ({out_valid, a, b} !== {1'b1, 32'd7, 32'd3}) begin
         errors++;
         $display("FAIL stall_load: got valid=%b a=%h b=%h want 1/7/3", out_valid, a, b);
      end
      issue(OP_SUB, 5'd6, 5'd5, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready_%0d: got %b want 0", i, in_ready);
         end
         tick();
         checks++;
         if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'd7, 32'd3, 6'b000_10_0}) begin
            errors++;
            $display("FAIL stall_hold_%0d: got valid=%b a=%h b=%h ctrl=%b, want 1/7/3/000100",
                     i, out_valid, a, b, ctrl_obs);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready: got %b want 1", in_ready);
      end
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'd3, 32'd7, 6'b011_10_0}) begin
         errors++;
         $display("FAIL b2b_first: got valid=%b a=%h b=%h ctrl=%b, want 1/3/7/011100",
                  out_valid, a, b, ctrl_obs);
      end
      issue(OP_OR, 5'd5, 5'd6, 1'b0, 16'h0);
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'd7, 32'd3, 6'b000_01_0}) begin
         errors++;
         $display("FAIL b2b_second: got valid=%b a=%h b=%h ctrl=%b, want 1/7/3/000010",
                  out_valid, a, b, ctrl_obs);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_hold_write();
      out_ready = 1'b0;
      issue(OP_ADD, 5'd5, 5'd6, 1'b0, 16'h0);
      tick();
      in_valid = 1'b0;
      write_reg(5'd5, 32'h0000_AAAA);
      tick();
      wr_en = 1'b0;
      tick();
      checks++;
      if ({out_valid, a} !== {1'b1, 32'd7}) begin
         errors++;
         $display("FAIL held_operand: got valid=%b a=%h want 1/7", out_valid, a);
      end
      out_ready = 1'b1;
      tick();
      issue(OP_OR, 5'd5, 5'd0, 1'b0, 16'h0);
      tick();
      checks++;
      if (a !== 32'h0000_AAAA) begin
         errors++;
         $display("FAIL write_committed: got a=%h want 0000aaaa", a);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      issue(OP_SUB, 5'd5, 5'd6, 1'b0, 16'h0);
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midflight_load: got out_valid=%b want 1", out_valid);
      end
      rst = 1'b1;
      issue(OP_NOR, 5'd5, 5'd6, 1'b0, 16'h0);
      write_reg(5'd7, 32'h0000_0005);
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1 ^ 1'b1, 32'h0, 32'h0, 6'b000000}) begin
         errors++;
         $display("FAIL midflight_reset: got valid=%b a=%h b=%h ctrl=%b, want 0/0/0/000000",
                  out_valid, a, b, ctrl_obs);
      end
      rst      = 1'b0;
      wr_en    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
      end
      out_ready = 1'b1;
      issue(OP_OR, 5'd5, 5'd7, 1'b0, 16'h0);
      tick();
      checks++;
      if ({out_valid, a, b, ctrl_obs} !== {1'b1, 32'h0, 32'h0, 6'b000_01_0}) begin
         errors++;
         $display("FAIL post_reset_regs: got valid=%b a=%h b=%h ctrl=%b, want 1/0/0/000010",
                  out_valid, a, b, ctrl_obs);
      end
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_op      = 4'h0;
      in_rs      = 5'd0;
      in_rt      = 5'd0;
      in_use_imm = 1'b0;
      in_imm     = 16'h0;
      wr_en      = 1'b0;
      wr_addr    = 5'd0;
      wr_data    = 32'h0;
      out_ready  = 1'b1;

      test_reset();
      test_sub();
      test_imm();
      test_forward();
      test_decode();
      test_back_to_back();
      test_hold_write();
      test_reset_midflight();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
